// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC frame scheduler: FSM state encoding,
// tick period floor and the word-index to front-end mapping.
package adc_sched_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

    // Frame word w belongs to front-end w/2; channel is the low bit.
    function automatic int unsigned word_adc(input int unsigned w);
        return w >> 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Programmable sampling tick: counter runs 0..P-1 with P = max(period, MIN_PERIOD)
// and pulses sample_tick on the terminal count.
module sample_tick_gen
    import adc_sched_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    sample_tick
);

    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] last;

    // A shrinking period can leave count past the new terminal value; >= forces a tick.
    always_comb begin
        if (period < PERIOD_WIDTH'(MIN_PERIOD)) begin
            last = PERIOD_WIDTH'(MIN_PERIOD - 1);
        end else begin
            last = period - PERIOD_WIDTH'(1);
        end
        sample_tick = enable && (count >= last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || sample_tick) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Latches dual-channel ADC results on eoc, snapshots them into a frame on each
// sampling tick and streams the frame out over AXI-Stream with stale flags.
module adc_frame_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned NUM_ADC      = 4,
    parameter int unsigned ADC_LENGTH   = 12,
    parameter int unsigned TDATA_WIDTH  = 16,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                            CLK100MHz,
    input  logic                            ARESETN,
    input  logic                            enable,
    input  logic [PERIOD_WIDTH-1:0]         period,
    input  logic [NUM_ADC-1:0]              eoc,
    input  logic [NUM_ADC*2*ADC_LENGTH-1:0] adc_data,
    output logic [TDATA_WIDTH-1:0]          m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    output logic                            sample_tick,
    output logic                            busy,
    output logic [15:0]                     overrun_cnt
);

    localparam int unsigned NUM_WORDS = 2 * NUM_ADC;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [ADC_LENGTH-1:0] shadow [NUM_WORDS];
    logic [ADC_LENGTH-1:0] frame  [NUM_WORDS];
    logic [NUM_ADC-1:0]    fresh;
    logic [NUM_ADC-1:0]    stale;
    logic [IDX_W-1:0]      word_idx;
    state_t                state, state_next;
    logic                  snapshot, drop, accept, last_word;

    sample_tick_gen #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_tick (
        .clk        (CLK100MHz),
        .rst_n      (ARESETN),
        .enable     (enable),
        .period     (period),
        .sample_tick(sample_tick)
    );

    always_comb begin
        state_next    = state;
        snapshot      = 1'b0;
        drop          = 1'b0;
        accept        = 1'b0;
        last_word     = (word_idx == LAST_IDX);
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_tick) begin
                    snapshot   = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                drop          = sample_tick;
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = TDATA_WIDTH'(frame[word_idx]);
                m_axis_tuser  = stale[word_adc(32'(word_idx))];
                m_axis_tlast  = last_word;
                accept        = m_axis_tready;
                if (accept && last_word) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHz or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot reads pre-edge shadow/fresh, so a coincident eoc lands in the next frame.
    always_ff @(posedge CLK100MHz or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                shadow[w] <= '0;
                frame[w]  <= '0;
            end
            fresh       <= '0;
            stale       <= '0;
            word_idx    <= '0;
            overrun_cnt <= '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                if (eoc[word_adc(w)]) begin
                    shadow[w] <= adc_data[w*ADC_LENGTH +: ADC_LENGTH];
                end
            end
            fresh <= eoc | (snapshot ? '0 : fresh);
            if (snapshot) begin
                for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                    frame[w] <= shadow[w];
                end
                stale    <= ~fresh;
                word_idx <= '0;
            end else if (accept && !last_word) begin
                word_idx <= word_idx + IDX_W'(1);
            end
            if (drop && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end

endmodule
